// File: rtl/step_pulse_gen.sv
// step_pulse_gen: single-step button conditioner producing step strobes
// for the core (debounce, auto-repeat, free-run) plus a pulse tally.
module step_pulse_gen #(
  parameter int DEBOUNCE_CYCLES = 500000,
  parameter int HOLD_CYCLES     = 50000000,
  parameter int REPEAT_CYCLES   = 10000000,
  parameter int RUN_CYCLES      = 25000000
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        button,
  input  logic        run_mode,
  output logic        step_pulse,
  output logic        btn_level,
  output logic [15:0] step_count
);

  localparam int MAX_DH =
    (DEBOUNCE_CYCLES > HOLD_CYCLES) ?
    DEBOUNCE_CYCLES : HOLD_CYCLES;
  localparam int MAX_RR =
    (REPEAT_CYCLES > RUN_CYCLES) ?
    REPEAT_CYCLES : RUN_CYCLES;
  localparam int MAX_P =
    (MAX_DH > MAX_RR) ? MAX_DH : MAX_RR;

  localparam int CW =
    (MAX_P > 1) ? $clog2(MAX_P) : 1;
  localparam int RW =
    (RUN_CYCLES > 1) ? $clog2(RUN_CYCLES) : 1;

  localparam logic [CW-1:0] DEB_LAST =
    CW'(DEBOUNCE_CYCLES - 1);
  localparam logic [CW-1:0] HOLD_LAST =
    CW'(HOLD_CYCLES - 1);
  localparam logic [CW-1:0] REP_LAST =
    CW'(REPEAT_CYCLES - 1);
  localparam logic [RW-1:0] RUN_LAST =
    RW'(RUN_CYCLES - 1);

  typedef enum logic [2:0] {
    IDLE,
    DEB_PRESS,
    HELD,
    REPEAT,
    DEB_RELEASE
  } state_t;

  logic [1:0]    b_sync;
  logic [1:0]    r_sync;
  logic          b_s;
  logic          r_s;
  state_t        state;
  logic [CW-1:0] cnt;
  logic [RW-1:0] run_cnt;
  logic          press;
  logic          run_wrap;
  logic          pulse_d;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      b_sync <= '0;
      r_sync <= '0;
    end else begin
      b_sync <= {b_sync[0], button};
      r_sync <= {r_sync[0], run_mode};
    end
  end

  assign b_s = b_sync[1];
  assign r_s = r_sync[1];

  // Pulse decision taken on the same edge the FSM acts on it.
  always_comb begin
    press = 1'b0;
    unique case (state)
      DEB_PRESS:
        press = b_s && (cnt == DEB_LAST);
      HELD:
        press = b_s && (cnt == HOLD_LAST);
      REPEAT:
        press = b_s && (cnt == REP_LAST);
      default:
        press = 1'b0;
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state     <= IDLE;
      cnt       <= '0;
      btn_level <= 1'b0;
    end else begin
      unique case (state)
        IDLE: begin
          if (b_s) begin
            state <= DEB_PRESS;
            cnt   <= '0;
          end
        end
        DEB_PRESS: begin
          if (!b_s) begin
            state <= IDLE;
          end else if (cnt == DEB_LAST) begin
            state     <= HELD;
            cnt       <= '0;
            btn_level <= 1'b1;
          end else begin
            cnt <= cnt + 1'b1;
          end
        end
        HELD: begin
          if (!b_s) begin
            state <= DEB_RELEASE;
            cnt   <= '0;
          end else if (cnt == HOLD_LAST) begin
            state <= REPEAT;
            cnt   <= '0;
          end else begin
            cnt <= cnt + 1'b1;
          end
        end
        REPEAT: begin
          if (!b_s) begin
            state <= DEB_RELEASE;
            cnt   <= '0;
          end else if (cnt == REP_LAST) begin
            cnt <= '0;
          end else begin
            cnt <= cnt + 1'b1;
          end
        end
        DEB_RELEASE: begin
          // A release bounce counts as still held.
          if (b_s) begin
            state <= HELD;
            cnt   <= '0;
          end else if (cnt == DEB_LAST) begin
            state     <= IDLE;
            btn_level <= 1'b0;
          end else begin
            cnt <= cnt + 1'b1;
          end
        end
        default: begin
          state <= IDLE;
          cnt   <= '0;
        end
      endcase
    end
  end

  assign run_wrap = (run_cnt == RUN_LAST);
  assign pulse_d  = r_s ? run_wrap : press;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      run_cnt <= '0;
    end else if (!r_s || run_wrap) begin
      run_cnt <= '0;
    end else begin
      run_cnt <= run_cnt + 1'b1;
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      step_pulse <= 1'b0;
      step_count <= '0;
    end else begin
      step_pulse <= pulse_d;
      if (step_pulse) begin
        step_count <= step_count + 16'd1;
      end
    end
  end

endmodule

// File: tb/tb_step_pulse_gen.sv
// tb_step_pulse_gen: directed checks of debounce, repeat, run mode,
// reset behaviour and step_count wrap.
module tb_step_pulse_gen;

  logic        clk = 1'b0;
  logic        rst;
  logic        button;
  logic        run_mode;
  logic        step_pulse;
  logic        btn_level;
  logic [15:0] step_count;

  logic        run_w;
  logic        btn_w;
  logic        sp_w;
  logic        lvl_w;
  logic [15:0] cnt_w;

  int n_chk  = 0;
  int n_pass = 0;
  int edge_n = 0;
  int pulses[$];
  int ex[10];
  int e0;
  int e1;
  int k;
  bit done;

  always #5 clk = ~clk;

  always @(posedge clk) edge_n <= edge_n + 1;

  always @(negedge clk) begin
    if (step_pulse) pulses.push_back(edge_n);
  end

  step_pulse_gen #(
    .DEBOUNCE_CYCLES(4),
    .HOLD_CYCLES    (20),
    .REPEAT_CYCLES  (8),
    .RUN_CYCLES     (5)
  ) u_dut (
    .clk       (clk),
    .rst       (rst),
    .button    (button),
    .run_mode  (run_mode),
    .step_pulse(step_pulse),
    .btn_level (btn_level),
    .step_count(step_count)
  );

  step_pulse_gen #(
    .DEBOUNCE_CYCLES(4),
    .HOLD_CYCLES    (20),
    .REPEAT_CYCLES  (8),
    .RUN_CYCLES     (1)
  ) u_wrap (
    .clk       (clk),
    .rst       (rst),
    .button    (btn_w),
    .run_mode  (run_w),
    .step_pulse(sp_w),
    .btn_level (lvl_w),
    .step_count(cnt_w)
  );

  task automatic chk(input string tag,
                     input int got,
                     input int exp);
    n_chk++;
    if (got != exp)
      $display("FAIL %s: got %0d, expected %0d",
               tag, got, exp);
    else
      n_pass++;
  endtask

  task automatic cyc(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic chk_train(input string tag,
                           input int base,
                           input int exp_off[10],
                           input int n);
    int got;
    chk({tag, "_npulse"}, pulses.size(), n);
    for (int i = 0; i < n; i++) begin
      got = (i < pulses.size()) ?
            pulses[i] - base : -1;
      chk($sformatf("%s_off%0d", tag, i),
          got, exp_off[i]);
    end
  endtask

  initial begin
    rst      = 1'b0;
    button   = 1'b0;
    run_mode = 1'b0;
    run_w    = 1'b0;
    btn_w    = 1'b0;

    // reset with a toggling button
    for (int i = 0; i < 3; i++) begin
      button = ~button;
      @(negedge clk);
    end
    chk("rst_sp", step_pulse, 0);
    chk("rst_lvl", btn_level, 0);
    chk("rst_cnt", step_count, 0);
    chk("rst_wcnt", cnt_w, 0);
    button = 1'b0;
    rst    = 1'b1;
    pulses.delete();
    cyc(50);
    chk("idle_npulse", pulses.size(), 0);
    chk("idle_cnt", step_count, 0);

    // clean press
    pulses.delete();
    e0 = edge_n;
    button = 1'b1;
    cyc(6);
    chk("clean_lvl_pre", btn_level, 0);
    cyc(1);
    chk("clean_sp", step_pulse, 1);
    chk("clean_lvl", btn_level, 1);
    cyc(8);
    button = 1'b0;
    e1 = edge_n;
    cyc(6);
    chk("clean_rel_hi", btn_level, 1);
    cyc(1);
    chk("clean_rel_lo", btn_level, 0);
    cyc(10);
    ex = '{7, 0, 0, 0, 0, 0, 0, 0, 0, 0};
    chk_train("clean", e0, ex, 1);
    chk("clean_cnt", step_count, 1);

    // press and release bounces
    pulses.delete();
    e0 = edge_n;
    for (int i = 0; i < 40; i++) begin
      if (i == 14) chk("bnc_lvl14", btn_level, 0);
      if (i == 30) chk("bnc_lvl30", btn_level, 1);
      if (i == 34) chk("bnc_lvl34", btn_level, 1);
      if (i == 35) chk("bnc_lvl35", btn_level, 0);
      button = (i < 2) ||
               (i >= 4 && i < 6) ||
               (i >= 8 && i < 20) ||
               (i >= 22 && i < 24) ||
               (i >= 26 && i < 28);
      @(negedge clk);
    end
    ex = '{15, 0, 0, 0, 0, 0, 0, 0, 0, 0};
    chk_train("bounce", e0, ex, 1);
    chk("bounce_cnt", step_count, 2);

    // auto-repeat
    pulses.delete();
    e0 = edge_n;
    button = 1'b1;
    cyc(60);
    button = 1'b0;
    cyc(15);
    ex = '{7, 27, 35, 43, 51, 59, 0, 0, 0, 0};
    chk_train("rpt", e0, ex, 6);
    chk("rpt_cnt", step_count, 8);

    // run mode, button press suppressed
    pulses.delete();
    e0 = edge_n;
    for (int i = 0; i < 52; i++) begin
      if (i == 25) chk("run_lvl_hi", btn_level, 1);
      if (i == 45) chk("run_lvl_lo", btn_level, 0);
      run_mode = 1'b1;
      button = (i >= 11 && i < 31);
      @(negedge clk);
    end
    run_mode = 1'b0;
    cyc(20);
    ex = '{7, 12, 17, 22, 27, 32, 37, 42, 47, 52};
    chk_train("run", e0, ex, 10);
    chk("run_cnt", step_count, 18);

    // run mode toggled mid-hold
    pulses.delete();
    e0 = edge_n;
    for (int i = 0; i < 38; i++) begin
      button   = 1'b1;
      run_mode = (i >= 8 && i < 18);
      @(negedge clk);
    end
    button   = 1'b0;
    run_mode = 1'b0;
    cyc(20);
    ex = '{7, 15, 20, 27, 35, 0, 0, 0, 0, 0};
    chk_train("mix", e0, ex, 5);
    chk("mix_cnt", step_count, 23);

    // reset during DEB_PRESS
    pulses.delete();
    button = 1'b1;
    cyc(4);
    rst = 1'b0;
    cyc(2);
    chk("mrst_cnt", step_count, 0);
    chk("mrst_lvl", btn_level, 0);
    rst = 1'b1;
    e1 = edge_n;
    cyc(12);
    ex = '{7, 0, 0, 0, 0, 0, 0, 0, 0, 0};
    chk_train("mrst", e1, ex, 1);
    chk("mrst_after", step_count, 1);
    button = 1'b0;
    cyc(12);

    // step_count wrap on the fast run instance
    k    = 0;
    done = 1'b0;
    run_w = 1'b1;
    for (int t = 0; t < 70000 && !done; t++) begin
      @(negedge clk);
      if (sp_w) begin
        k++;
        if (k == 65536) done = 1'b1;
      end
    end
    chk("wrap_seen", k, 65536);
    chk("wrap_pre", cnt_w, 16'hFFFF);
    @(negedge clk);
    chk("wrap_zero", cnt_w, 0);
    chk("wrap_lvl", lvl_w, 0);

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
